// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered read data, occupancy count,
// level flags decoded from the registered count, and sticky
// overflow/underflow error flags with a synchronous clear.
module sync_fifo_flags #(
    parameter int DEPTH     = 16,
    parameter int PTRWIDTH  = 4,
    parameter int DWIDTH    = 8,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                push,
    input  logic [DWIDTH-1:0]   wdata,
    input  logic                pop,
    output logic [DWIDTH-1:0]   rdata,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [PTRWIDTH:0]   count,
    output logic                overflow,
    output logic                underflow,
    input  logic                clr_err
);

    localparam logic [PTRWIDTH:0]   CNT_DEPTH = (PTRWIDTH+1)'(DEPTH);
    localparam logic [PTRWIDTH:0]   CNT_AFULL = (PTRWIDTH+1)'(AFULL_TH);
    localparam logic [PTRWIDTH:0]   CNT_AEMPT = (PTRWIDTH+1)'(AEMPTY_TH);
    localparam logic [PTRWIDTH:0]   CNT_ONE   = (PTRWIDTH+1)'(1);
    localparam logic [PTRWIDTH-1:0] PTR_ONE   = PTRWIDTH'(1);

    logic [DWIDTH-1:0]   mem [DEPTH];
    logic [PTRWIDTH-1:0] wrptr;
    logic [PTRWIDTH-1:0] rdptr;
    logic                push_acc;
    logic                pop_acc;
    logic                push_rej;
    logic                pop_rej;

    // Accept/reject decode. A push into a full FIFO is legal when a pop
    // frees the slot on the same edge; a pop never bypasses an empty FIFO.
    always_comb begin
        pop_acc  = pop & ~empty;
        push_acc = push & (~full | pop);
        push_rej = push & full & ~pop;
        pop_rej  = pop & empty;
    end

    // Level flags come from the registered count only, so there is no
    // combinational path from push/pop to any flag.
    always_comb begin
        full         = (count == CNT_DEPTH);
        empty        = (count == '0);
        almost_full  = (count >= CNT_AFULL);
        almost_empty = (count <= CNT_AEMPT);
    end

    // Storage write; memory contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_acc)
            mem[wrptr] <= wdata;
    end

    // Write pointer wraps naturally at DEPTH = 2**PTRWIDTH.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            wrptr <= '0;
        else if (push_acc)
            wrptr <= wrptr + PTR_ONE;
    end

    // Read pointer and registered read data. When full with push and pop
    // together, wrptr == rdptr and the old entry is read here before the
    // write on the same edge lands.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rdptr <= '0;
            rdata <= '0;
        end else if (pop_acc) begin
            rdptr <= rdptr + PTR_ONE;
            rdata <= mem[rdptr];
        end
    end

    // Occupancy: moves only when exactly one side is accepted.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            count <= '0;
        else if (push_acc && !pop_acc)
            count <= count + CNT_ONE;
        else if (pop_acc && !push_acc)
            count <= count - CNT_ONE;
    end

    // Sticky error flags; a new error wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push_rej | (overflow  & ~clr_err);
            underflow <= pop_rej  | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomized and directed bench for sync_fifo_flags against a queue model.
module tb_sync_fifo_flags;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;
    localparam int AEMPT = 2;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [7:0] q[$];
    logic [7:0] m_rdata = '0;
    bit         m_ovf = 0;
    bit         m_unf = 0;

    sync_fifo_flags #(.DEPTH(16), .PTRWIDTH(4), .DWIDTH(8),
                      .AFULL_TH(AFULL), .AEMPTY_TH(AEMPT)) dut (
        .clk(clk), .reset_L(reset_L), .push(push), .wdata(wdata), .pop(pop),
        .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},  int'(count),        n);
        chk({tag, ".full"},   int'(full),         int'(n == DEPTH));
        chk({tag, ".empty"},  int'(empty),        int'(n == 0));
        chk({tag, ".afull"},  int'(almost_full),  int'(n >= AFULL));
        chk({tag, ".aempty"}, int'(almost_empty), int'(n <= AEMPT));
        chk({tag, ".rdata"},  int'(rdata),        int'(m_rdata));
        chk({tag, ".ovf"},    int'(overflow),     int'(m_ovf));
        chk({tag, ".unf"},    int'(underflow),    int'(m_unf));
    endtask

    // One clock cycle: drive at negedge, model the edge, check at next negedge.
    task automatic step(input string tag, input bit p, input bit o,
                        input logic [7:0] d, input bit c);
        int  n;
        bit  pa, pr, oa, orj;
        push = p; pop = o; wdata = d; clr_err = c;
        n   = q.size();
        oa  = o && n > 0;
        orj = o && n == 0;
        pa  = p && (n < DEPTH || o);
        pr  = p && n == DEPTH && !o;
        if (oa) m_rdata = q.pop_front();
        if (pa) q.push_back(d);
        m_ovf = pr  || (m_ovf && !c);
        m_unf = orj || (m_unf && !c);
        @(posedge clk);
        @(negedge clk);
        push = 0; pop = 0; clr_err = 0;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata = '0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    initial begin
        int n;
        bit p, o;
        // reset state
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        reset_L = 1'b1;

        // fill 0x00..0x0F, then a rejected push
        for (int i = 0; i < 16; i++) step("fill", 1, 0, 8'(i), 0);
        step("ovf_push", 1, 0, 8'hEE, 0);
        // clear overflow
        step("clr_ovf", 0, 0, 8'h00, 1);

        // drain in order, then a rejected pop
        for (int i = 0; i < 16; i++) step("drain", 0, 1, 8'h00, 0);
        step("unf_pop", 0, 1, 8'h00, 0);
        // clear together with a rejected pop keeps underflow
        step("clr_vs_unf", 0, 1, 8'h00, 1);
        step("clr_unf", 0, 0, 8'h00, 1);

        // push+pop on empty: push only, underflow sets
        step("pp_empty", 1, 1, 8'h5A, 0);
        step("pop1", 0, 1, 8'h00, 1);

        // refill 0x00..0x0F then push+pop on full
        for (int i = 0; i < 16; i++) step("refill", 1, 0, 8'(i), 0);
        step("pp_full", 1, 1, 8'hA5, 0);

        // bring count into 1..15 and run random wrap traffic
        for (int i = 0; i < 4; i++) step("pre_wrap", 0, 1, 8'h00, 0);
        for (int i = 0; i < 80; i++) begin
            n = q.size();
            p = $urandom_range(0, 1) == 1;
            o = $urandom_range(0, 1) == 1;
            if (n <= 1)  o = 0;
            if (n >= 15) p = 0;
            if (!p && !o) begin
                if (n <= 1) p = 1; else o = 1;
            end
            step("wrap", p, o, 8'($urandom), 0);
        end

        // drain, refill to 7, then reset mid-fill
        while (q.size() > 0) step("predrain", 0, 1, 8'h00, 0);
        for (int i = 0; i < 7; i++) step("fill7", 1, 0, 8'($urandom), 0);
        #2 reset_L = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        reset_L = 1'b1;
        step("pop_after_rst", 0, 1, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
